// File: rtl/dma_word_controller.sv
// Word-granular DMA controller: moves one word per device handshake between a DMA
// device and the CPU's DMA memory port, flagging completion and memory errors.
module dma_word_controller #(
  parameter logic DMA_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dev_rqst,
  input  logic        dev_rd_wr,
  input  logic [15:0] dev_start_addr,
  input  logic [15:0] dev_num_words,
  input  logic [15:0] dev_data_out,
  input  logic        dev_ack,
  output logic        dma_ack,
  output logic        dma_end_flag,
  output logic        dma_err,
  output logic [15:0] dev_data_in,
  output logic [14:0] mem_addr,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  output logic [15:0] mem_din,
  output logic        mem_priority,
  input  logic [15:0] mem_dout,
  input  logic        mem_ready,
  input  logic        mem_resp
);

  typedef enum logic [2:0] {
    IDLE, WAIT_DEV, ACCESS, RDATA, ACK, HOLD, DONE
  } state_t;

  state_t      state, state_next;
  logic        rd_q;
  logic [15:0] addr_q;
  logic [15:0] cnt_q;
  logic        set_err;
  logic        capture;

  assign capture      = (state == IDLE) && dev_rqst;
  assign mem_priority = DMA_PRIORITY;
  assign mem_din      = (state == ACCESS) ? dev_data_out : 16'd0;

  always_comb begin
    state_next = state;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (dev_rqst) state_next = (dev_num_words == 16'd0) ? DONE : WAIT_DEV;
      end
      WAIT_DEV: begin
        if (!dev_rqst)    state_next = IDLE;
        else if (dev_ack) state_next = ACCESS;
      end
      ACCESS: begin
        if (mem_ready) state_next = rd_q ? RDATA : ACK;
      end
      RDATA: begin
        if (mem_resp) begin
          set_err    = 1'b1;
          state_next = DONE;
        end else begin
          state_next = ACK;
        end
      end
      ACK: begin
        // A write error reported in the ack cycle aborts after the pulse already issued.
        if (!rd_q && mem_resp) begin
          set_err    = 1'b1;
          state_next = DONE;
        end else begin
          state_next = (cnt_q == 16'd1) ? DONE : HOLD;
        end
      end
      HOLD: begin
        state_next = dev_rqst ? WAIT_DEV : IDLE;
      end
      DONE: begin
        if (!dev_rqst) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dma_ack      <= 1'b0;
      dma_end_flag <= 1'b0;
      dma_err      <= 1'b0;
      dev_data_in  <= 16'd0;
      mem_en       <= 1'b0;
      mem_we       <= 2'b00;
      mem_addr     <= 15'd0;
    end else begin
      state        <= state_next;
      dma_ack      <= (state_next == ACK);
      dma_end_flag <= (state_next == DONE);
      mem_en       <= (state_next == ACCESS);
      mem_we       <= ((state_next == ACCESS) && !rd_q) ? 2'b11 : 2'b00;
      mem_addr     <= (state_next == ACCESS) ? addr_q[15:1] : 15'd0;
      if (capture)      dma_err <= 1'b0;
      else if (set_err) dma_err <= 1'b1;
      if ((state == RDATA) && !mem_resp) dev_data_in <= mem_dout;
    end
  end

  // Transfer descriptor: only meaningful once captured, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      rd_q   <= dev_rd_wr;
      addr_q <= dev_start_addr & 16'hFFFE;
      cnt_q  <= dev_num_words;
    end else if (state == ACK) begin
      addr_q <= addr_q + 16'd2;
      cnt_q  <= cnt_q - 16'd1;
    end
  end

endmodule

// File: tb/tb_dma_word_controller.sv
// Self-checking bench for dma_word_controller: a memory/device model feeds randomized
// transfers, and each scenario task compares the DUT against the expected word sequence.
module tb_dma_word_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev_rqst, dev_rd_wr, dev_ack;
  logic [15:0] dev_start_addr, dev_num_words, dev_data_out;
  logic        dma_ack, dma_end_flag, dma_err;
  logic [15:0] dev_data_in;
  logic [14:0] mem_addr;
  logic        mem_en;
  logic [1:0]  mem_we;
  logic [15:0] mem_din;
  logic        mem_priority;
  logic [15:0] mem_dout  = 16'd0;
  logic        mem_ready = 1'b0;
  logic        mem_resp  = 1'b0;

  int n_pass, n_total;

  dma_word_controller dut (
    .clk(clk), .reset(reset),
    .dev_rqst(dev_rqst), .dev_rd_wr(dev_rd_wr), .dev_start_addr(dev_start_addr),
    .dev_num_words(dev_num_words), .dev_data_out(dev_data_out), .dev_ack(dev_ack),
    .dma_ack(dma_ack), .dma_end_flag(dma_end_flag), .dma_err(dma_err),
    .dev_data_in(dev_data_in), .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_din(mem_din), .mem_priority(mem_priority), .mem_dout(mem_dout),
    .mem_ready(mem_ready), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  // Memory model: random wait states, logs every accepted access, optional error response.
  logic [15:0] mem_arr [0:32767];
  int          wait_min = 0, wait_max = 0, err_at = -1, acc_idx = 0;
  int          waits_left = 0, cur_wait = 0, stab_err = 0;
  bit          hold_active = 1'b0, resp_pend = 1'b0;
  logic [14:0] hold_addr;
  logic [1:0]  hold_we;
  logic [14:0] acc_addr [$];
  logic [1:0]  acc_we [$];
  logic [15:0] acc_din [$];
  int          acc_wait [$];

  always @(negedge clk) begin
    mem_resp  = resp_pend;
    resp_pend = 1'b0;
    if (mem_en && !reset) begin
      if (!hold_active) begin
        hold_active = 1'b1;
        hold_addr   = mem_addr;
        hold_we     = mem_we;
        cur_wait    = int'($urandom_range(wait_max, wait_min));
        waits_left  = cur_wait;
      end else if (mem_addr !== hold_addr || mem_we !== hold_we) begin
        stab_err++;
      end
      if (waits_left > 0) begin
        mem_ready = 1'b0;
        waits_left--;
      end else begin
        mem_ready   = 1'b1;
        hold_active = 1'b0;
        acc_addr.push_back(mem_addr);
        acc_we.push_back(mem_we);
        acc_din.push_back(mem_din);
        acc_wait.push_back(cur_wait);
        if (mem_we == 2'b11) mem_arr[mem_addr] = mem_din;
        else                 mem_dout = mem_arr[mem_addr];
        resp_pend = (acc_idx == err_at);
        acc_idx++;
      end
    end else begin
      if (hold_active && !reset) stab_err++;
      hold_active = 1'b0;
      mem_ready   = 1'b0;
    end
  end

  task automatic mem_setup(input int wmin, input int wmax, input int err);
    acc_addr.delete(); acc_we.delete(); acc_din.delete(); acc_wait.delete();
    acc_idx  = 0;
    err_at   = err;
    wait_min = wmin;
    wait_max = wmax;
    stab_err = 0;
  endtask

  // One complete transfer with dev_ack held high, checked against the word-level model.
  task automatic run_xfer(input bit rd, input logic [15:0] start, input int n,
                          input int wmin, input int wmax, input int err, input int hold);
    logic [15:0] wdata [$];
    int          ack_cyc [$];
    logic [15:0] ack_data [$];
    int          end_cyc, k, n_acc, n_ack, sumw, exp_t, stay, lim;
    bit          errv;
    logic [14:0] a;
    for (int i = 0; i < n; i++) wdata.push_back(16'($urandom));
    mem_setup(wmin, wmax, err);
    dev_rd_wr      = rd;
    dev_start_addr = start;
    dev_num_words  = 16'(n);
    dev_ack        = 1'b1;
    if (n > 0) dev_data_out = wdata[0];
    dev_rqst = 1'b1;
    end_cyc  = -1;
    k        = 0;
    for (int c = 1; c <= 400 && end_cyc < 0; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        n_total++;
        if (dma_err !== 1'b0) $display("FAIL err_clear_on_capture: got %b want 0", dma_err);
        else n_pass++;
        dev_rd_wr      = ~rd;
        dev_start_addr = 16'($urandom);
        dev_num_words  = 16'($urandom);
      end
      if (dma_ack === 1'b1) begin
        ack_cyc.push_back(c);
        ack_data.push_back(dev_data_in);
        k++;
        if (k < n) dev_data_out = wdata[k];
      end
      if (dma_end_flag === 1'b1) end_cyc = c;
    end

    errv  = (err >= 0) && (err < n);
    n_acc = errv ? err + 1 : n;
    n_ack = errv ? (rd ? err : err + 1) : n;

    n_total++;
    if (end_cyc < 0) $display("FAIL end_flag_timeout: got none want end within 400 cycles");
    else n_pass++;
    n_total++;
    if (acc_addr.size() != n_acc) $display("FAIL access_count: got %0d want %0d", acc_addr.size(), n_acc);
    else n_pass++;
    n_total++;
    if (ack_cyc.size() != n_ack) $display("FAIL ack_count: got %0d want %0d", ack_cyc.size(), n_ack);
    else n_pass++;
    n_total++;
    if (dma_err !== errv) $display("FAIL dma_err_at_end: got %b want %b", dma_err, errv);
    else n_pass++;
    n_total++;
    if (stab_err != 0) $display("FAIL access_stability: got %0d changes want 0", stab_err);
    else n_pass++;

    lim = (acc_addr.size() < n_acc) ? acc_addr.size() : n_acc;
    for (int i = 0; i < lim; i++) begin
      a = 15'(int'(start[15:1]) + i);
      n_total++;
      if (acc_addr[i] !== a || acc_we[i] !== (rd ? 2'b00 : 2'b11))
        $display("FAIL access_%0d: got addr %h we %b want addr %h we %b", i, acc_addr[i], acc_we[i], a, rd ? 2'b00 : 2'b11);
      else n_pass++;
      if (!rd) begin
        n_total++;
        if (acc_din[i] !== wdata[i]) $display("FAIL write_data_%0d: got %h want %h", i, acc_din[i], wdata[i]);
        else n_pass++;
      end
    end

    sumw = 0;
    lim  = (ack_cyc.size() < n_ack) ? ack_cyc.size() : n_ack;
    for (int i = 0; i < lim && i < acc_wait.size(); i++) begin
      sumw += acc_wait[i];
      exp_t = 2 + i * (rd ? 5 : 4) + sumw + (rd ? 2 : 1);
      n_total++;
      if (ack_cyc[i] != exp_t) $display("FAIL ack_time_%0d: got cycle %0d want %0d", i, ack_cyc[i], exp_t);
      else n_pass++;
      if (rd) begin
        a = 15'(int'(start[15:1]) + i);
        n_total++;
        if (ack_data[i] !== mem_arr[a]) $display("FAIL read_data_%0d: got %h want %h", i, ack_data[i], mem_arr[a]);
        else n_pass++;
      end
    end

    if (!errv && n == 0) begin
      n_total++;
      if (end_cyc != 1) $display("FAIL zero_count_end_time: got %0d want 1", end_cyc);
      else n_pass++;
    end else if (!errv && ack_cyc.size() == n) begin
      n_total++;
      if (end_cyc != ack_cyc[n-1] + 1) $display("FAIL end_time: got %0d want %0d", end_cyc, ack_cyc[n-1] + 1);
      else n_pass++;
    end

    if (hold > 0) begin
      stay = 0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk); #1;
        if (dma_end_flag === 1'b1 && mem_en === 1'b0) stay++;
      end
      n_total++;
      if (stay != hold) $display("FAIL end_flag_held: got %0d cycles want %0d", stay, hold);
      else n_pass++;
    end

    dev_rqst = 1'b0;
    @(negedge clk); #1;
    n_total++;
    if (dma_end_flag !== 1'b0 || dma_ack !== 1'b0)
      $display("FAIL end_flag_release: got end %b ack %b want 0 0", dma_end_flag, dma_ack);
    else n_pass++;
    dev_ack = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    logic [52:0] outs;
    @(negedge clk); #1;
    outs = {dma_ack, dma_end_flag, dma_err, dev_data_in, mem_en, mem_we, mem_addr, mem_din};
    n_total++;
    if (outs !== 53'd0) $display("FAIL reset_outputs: got %h want 0", outs);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    outs = {dma_ack, dma_end_flag, dma_err, dev_data_in, mem_en, mem_we, mem_addr, mem_din};
    n_total++;
    if (outs !== 53'd0) $display("FAIL idle_outputs: got %h want 0", outs);
    else n_pass++;
    n_total++;
    if (mem_priority !== 1'b0) $display("FAIL mem_priority: got %b want 0", mem_priority);
    else n_pass++;
  endtask

  task automatic test_write_3();
    run_xfer(1'b0, 16'h0200, 3, 0, 0, -1, 0);
  endtask

  task automatic test_read_waits();
    mem_arr[15'h0180] = 16'hA5A5;
    mem_arr[15'h0181] = 16'h5A5A;
    run_xfer(1'b1, 16'h0300, 2, 2, 2, -1, 1);
  endtask

  task automatic test_zero_wrap();
    run_xfer(1'b0, 16'h0800, 0, 0, 0, -1, 4);
    run_xfer(1'b1, 16'hFFFE, 2, 0, 1, -1, 0);
    run_xfer(1'b0, 16'hFFFF, 2, 0, 0, -1, 0);
  endtask

  task automatic test_handshake();
    int seen_en, c;
    mem_setup(0, 0, -1);
    dev_rd_wr = 1'b0; dev_start_addr = 16'h1000; dev_num_words = 16'd2;
    dev_data_out = 16'h1111; dev_ack = 1'b0; dev_rqst = 1'b1;
    seen_en = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (mem_en === 1'b1) seen_en++;
    end
    n_total++;
    if (seen_en != 0) $display("FAIL ack_low_no_access: got %0d mem_en cycles want 0", seen_en);
    else n_pass++;
    dev_ack = 1'b1;
    c = 0;
    while (dma_ack !== 1'b1 && c < 20) begin @(negedge clk); #1; c++; end
    n_total++;
    if (dma_ack !== 1'b1) $display("FAIL handshake_first_ack: got %b want 1", dma_ack);
    else n_pass++;
    dev_ack = 1'b0; dev_data_out = 16'h2222;
    @(negedge clk); #1;
    dev_ack = 1'b1;
    seen_en = 0;
    @(negedge clk); #1;
    if (mem_en === 1'b1) seen_en++;
    dev_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (mem_en === 1'b1) seen_en++;
    end
    n_total++;
    if (seen_en != 0 || acc_addr.size() != 1)
      $display("FAIL hold_ack_ignored: got %0d mem_en cycles, %0d accesses want 0, 1", seen_en, acc_addr.size());
    else n_pass++;
    dev_ack = 1'b1;
    c = 0;
    while (dma_end_flag !== 1'b1 && c < 20) begin @(negedge clk); #1; c++; end
    n_total++;
    if (dma_end_flag !== 1'b1 || acc_addr.size() != 2) $display("FAIL handshake_finish: got end %b acc %0d want 1 2", dma_end_flag, acc_addr.size());
    else n_pass++;
    if (acc_addr.size() == 2) begin
      n_total++;
      if (acc_addr[1] !== 15'h0801 || acc_din[1] !== 16'h2222)
        $display("FAIL handshake_word2: got %h/%h want 0801/2222", acc_addr[1], acc_din[1]);
      else n_pass++;
    end
    dev_rqst = 1'b0; dev_ack = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
  endtask

  task automatic test_abort();
    int c, bad;
    logic [52:0] outs;
    mem_setup(0, 0, -1);
    dev_rd_wr = 1'b0; dev_start_addr = 16'h2000; dev_num_words = 16'd4;
    dev_data_out = 16'h3333; dev_ack = 1'b1; dev_rqst = 1'b1;
    c = 0;
    while (dma_ack !== 1'b1 && c < 20) begin @(negedge clk); #1; c++; end
    dev_ack = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    dev_rqst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (dma_end_flag !== 1'b0 || mem_en !== 1'b0 || dma_ack !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0 || acc_addr.size() != 1)
      $display("FAIL rqst_drop_abort: got %0d bad cycles, %0d accesses want 0, 1", bad, acc_addr.size());
    else n_pass++;

    mem_setup(4, 4, -1);
    dev_rd_wr = 1'b1; dev_start_addr = 16'h3000; dev_num_words = 16'd2;
    dev_ack = 1'b1; dev_rqst = 1'b1;
    c = 0;
    while (mem_en !== 1'b1 && c < 10) begin @(negedge clk); #1; c++; end
    n_total++;
    if (mem_en !== 1'b1) $display("FAIL reset_reach_access: got mem_en %b want 1", mem_en);
    else n_pass++;
    reset = 1'b1;
    #1;
    outs = {dma_ack, dma_end_flag, dma_err, dev_data_in, mem_en, mem_we, mem_addr, mem_din};
    n_total++;
    if (outs !== 53'd0) $display("FAIL async_reset_outputs: got %h want 0", outs);
    else n_pass++;
    dev_rqst = 1'b0; dev_ack = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    n_total++;
    if (acc_addr.size() != 0 || mem_en !== 1'b0)
      $display("FAIL reset_drops_access: got %0d accesses mem_en %b want 0 0", acc_addr.size(), mem_en);
    else n_pass++;
  endtask

  task automatic test_mem_err();
    run_xfer(1'b1, 16'h0400, 3, 0, 0, 1, 2);
    n_total++;
    if (dma_err !== 1'b1) $display("FAIL err_sticky_idle: got %b want 1", dma_err);
    else n_pass++;
    run_xfer(1'b0, 16'h0500, 3, 0, 1, 1, 0);
    run_xfer(1'b1, 16'h0600, 2, 0, 1, -1, 0);
  endtask

  task automatic test_random();
    int n, err;
    for (int t = 0; t < 25; t++) begin
      n   = int'($urandom_range(6, 1));
      err = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      run_xfer(1'($urandom), 16'($urandom), n, 0, int'($urandom_range(3, 0)), err,
               int'($urandom_range(2, 0)));
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    for (int i = 0; i < 32768; i++) mem_arr[i] = 16'($urandom);
    reset = 1'b1;
    dev_rqst = 1'b0; dev_rd_wr = 1'b0; dev_ack = 1'b0;
    dev_start_addr = 16'd0; dev_num_words = 16'd0; dev_data_out = 16'd0;
    test_reset();
    test_write_3();
    test_read_waits();
    test_zero_wrap();
    test_handshake();
    test_abort();
    test_mem_err();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dma_word_controller.md
# dma_word_controller

Word-granular DMA controller between the DMA peripheral devices and the CPU core's DMA memory port. It accepts one transfer request from a device: start address, word count and direction. It then moves data one word at a time between memory and the device using a two-phase handshake, `dma_ack` out and `dev_ack` in. When the last word has moved, or the transfer aborts on a memory error, it raises `dma_end_flag`.

## Interface
- `DMA_PRIORITY`, default 1'b0, constant value driven on `mem_priority`.
- `clk` in 1: main system clock.
- `reset` in 1: asynchronous, active-high reset.
- `dev_rqst` in 1: transfer request, level; held by the device for the whole transfer.
- `dev_rd_wr` in 1: direction; 1 = memory→device (read), 0 = device→memory (write).
- `dev_start_addr` in 16: byte address of the first word; bit 0 is ignored.
- `dev_num_words` in 16: number of words to transfer.
- `dev_data_out` in 16: write data from the device.
- `dev_ack` in 1: device ready for the next word.
- `dma_ack` out 1: one-cycle pulse per completed word.
- `dma_end_flag` out 1: transfer finished or aborted.
- `dma_err` out 1: sticky memory-error flag.
- `dev_data_in` out 16: read data presented to the device.
- `mem_addr` out 15: word address.
- `mem_en` out 1: memory access request.
- `mem_we` out 2: byte write enables.
- `mem_din` out 16: write data to memory.
- `mem_priority` out 1: memory port priority.
- `mem_dout` in 16: memory read data.
- `mem_ready` in 1: access accepted.
- `mem_resp` in 1: error response.

## Operation
- States: IDLE, WAIT_DEV, ACCESS, RDATA, ACK, HOLD, DONE.
- **IDLE**
  - On `dev_rqst`=1: capture `dev_rd_wr`, `addr_q`=`dev_start_addr`&16'hFFFE and `cnt_q`=`dev_num_words`.
  - Clear `dma_err`.
  - Go to DONE if `dev_num_words`==0, otherwise to WAIT_DEV.
  - Device inputs other than `dev_data_out` and `dev_ack` are ignored after capture.
- **WAIT_DEV**
  - `dev_rqst`=0 → IDLE, without raising `dma_end_flag`.
  - Otherwise, `dev_ack`=1 → ACCESS.
- **ACCESS**
  - Drive `mem_en`=1 and `mem_addr`=`addr_q[15:1]`.
  - Writes: `mem_we`=2'b11 and `mem_din`=`dev_data_out`. Reads: `mem_we`=0.
  - All access signals are held stable until `mem_ready`=1.
  - On accept: write → ACK; read → RDATA.
- **RDATA**
  - `dev_data_in` ← `mem_dout`; go to ACK.
  - `mem_resp`=1 in this cycle → set `dma_err`, go to DONE, no ack.
- **Write error:** `mem_resp`=1 in the cycle after a write accept sets `dma_err` and forces DONE at the next edge. The ACK pulse already issued stands.
- **ACK**
  - `dma_ack`=1 for one cycle.
  - `addr_q` += 2, wrapping 16'hFFFE→16'h0000.
  - `cnt_q` −= 1.
  - `cnt_q` was 1 → DONE, otherwise → HOLD.
- **HOLD**
  - One cycle in which `dev_ack` is ignored, so the device can retract its ack; then → WAIT_DEV.
  - `dev_rqst`=0 here → IDLE.
- **DONE**
  - `dma_end_flag`=1, held until `dev_rqst`=0, then → IDLE.
- **Request dropped mid-access:** `dev_rqst` falling during ACCESS does not cut the access. The access completes, the word is acked, and the controller then returns to IDLE from HOLD or DONE.
- **Reset:** asynchronous reset in any state returns to IDLE. A pending memory access is dropped immediately.

## Timing
- Reset values: `dma_ack`=0, `dma_end_flag`=0, `dma_err`=0, `dev_data_in`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0. `mem_priority`=`DMA_PRIORITY` at all times.
- All outputs are registered, except that `mem_din` follows `dev_data_out` combinationally while in ACCESS; `mem_din`=0 outside ACCESS.
- Request to first `mem_en`: 2 cycles (IDLE capture, WAIT_DEV) when `dev_ack`=1.
- Per word, with zero wait states and `dev_ack` held high:
  - write: 4 cycles (WAIT_DEV, ACCESS, ACK, HOLD);
  - read: 5 cycles (adds RDATA).
- Each `mem_ready`=0 cycle in ACCESS adds 1 cycle.
- `dev_data_in` is valid from the ACK cycle until the next read's RDATA.
- `dma_end_flag` rises the cycle after the last ACK.
- With `dev_num_words`=0, `dma_end_flag` rises 1 cycle after the request is captured and no memory access is made.

## Test plan
- **Write, 3 words:** `dev_rd_wr`=0, start 16'h0200, count 3, `dev_ack`=1, `mem_ready`=1 → writes to word addresses 15'h0100/0101/0102 with data as presented. Three `dma_ack` pulses 4 cycles apart; `dma_end_flag` the cycle after the third pulse.
- **Read with wait states:** `dev_rd_wr`=1, start 16'h0300, count 2, memory returns 16'hA5A5 then 16'h5A5A, `mem_ready` low for 2 cycles per access → `dev_data_in` equals each value during its `dma_ack`; `mem_en` and `mem_addr` stable while `mem_ready` is low.
- **Zero count and wrap:** count 0 → no `mem_en`, `dma_end_flag`=1 until `dev_rqst` drops. Start 16'hFFFE, count 2 → second access at word address 15'h0000.
- **Device handshake:** `dev_ack` held 0 for 10 cycles in WAIT_DEV → no `mem_en`. `dev_ack` high during HOLD only → not honoured.
- **Aborts:** `dev_rqst` dropped in WAIT_DEV after word 1 of 4 → IDLE, no `dma_end_flag`. Reset asserted during ACCESS → all outputs 0 immediately.
- **Memory error:** `mem_resp`=1 on read word 2 → no ack for word 2, `dma_err`=1 and `dma_end_flag`=1. `dma_err` clears on the next request.
